// File: rtl/lsu_dbus_master.sv
// lsu_dbus_master: MEM-stage load/store unit driving a single-outstanding request/response data bus
module lsu_dbus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          ALIGN_CHECK    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_valid_i,
  input  logic        mem_rd_en_i,
  input  logic        mem_wr_en_i,
  input  logic [3:0]  mem_ctrl_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        load_valid_o,
  output logic [31:0] load_data_o,
  output logic        misalign_o,
  output logic        err_o,
  output logic [31:0] fault_addr_o,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_be_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_gnt_i,
  input  logic        dbus_rvalid_i,
  input  logic [31:0] dbus_rdata_i,
  input  logic        dbus_err_i
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t      state;
  logic [7:0]  cnt;
  logic [1:0]  size_q;
  logic        sign_q, killed;
  logic [31:0] addr_q;
  logic [1:0]  size;
  logic        access, misaligned, tmo, resp, abort, tout, fin, berr, kill, ld_ok;
  logic [3:0]  be;
  logic [31:0] wdata_fmt, ld_fmt;
  logic [7:0]  b;
  logic [15:0] h;
  logic        unused_ctrl;
  assign unused_ctrl = mem_ctrl_i[3];
  assign size        = mem_ctrl_i[1:0];
  assign access      = pc_valid_i & (mem_rd_en_i | mem_wr_en_i) & ~flush_i;
  assign misaligned  = ALIGN_CHECK & ((size == 2'd1 & addr_i[0]) | (size[1] & |addr_i[1:0]));
  assign tmo         = cnt == 8'(TIMEOUT_CYCLES - 1);
  assign stall_o     = (state == IDLE & access & ~misaligned) | state == REQ | state == WAIT;
  assign dbus_req_o  = state == REQ;
  assign dbus_addr_o = {addr_q[31:2], 2'b00};
  // Lane formatting for the request being launched and the response being returned
  always_comb begin
    be        = size == 2'd0 ? 4'b0001 << addr_i[1:0] : size == 2'd1 ? (addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_fmt = size == 2'd0 ? {4{wdata_i[7:0]}} : size == 2'd1 ? {2{wdata_i[15:0]}} : wdata_i;
    b         = dbus_rdata_i[{addr_q[1:0], 3'b000} +: 8];
    h         = dbus_rdata_i[{addr_q[1], 4'b0000} +: 16];
    ld_fmt    = size_q == 2'd0 ? {{24{sign_q & b[7]}}, b} : size_q == 2'd1 ? {{16{sign_q & h[15]}}, h} : dbus_rdata_i;
  end
  // Completion conditions: a response in WAIT wins over a coincident timeout
  always_comb begin
    resp  = state == WAIT & dbus_rvalid_i;
    abort = state == REQ & flush_i & ~dbus_gnt_i;
    tout  = (state == REQ | state == WAIT) & tmo & ~resp & ~abort;
    fin   = resp | tout;
    berr  = tout | (resp & dbus_err_i);
    kill  = killed | flush_i;
    ld_ok = resp & ~dbus_err_i & ~dbus_we_o;
  end
  // Transaction FSM with registered bus fields and one-cycle result pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      size_q       <= '0;
      sign_q       <= 1'b0;
      killed       <= 1'b0;
      addr_q       <= '0;
      dbus_we_o    <= 1'b0;
      dbus_be_o    <= '0;
      dbus_wdata_o <= '0;
      load_valid_o <= 1'b0;
      load_data_o  <= '0;
      misalign_o   <= 1'b0;
      err_o        <= 1'b0;
      fault_addr_o <= '0;
    end else begin
      misalign_o   <= 1'b0;
      load_valid_o <= 1'b0;
      err_o        <= 1'b0;
      if (state == IDLE) begin
        if (access & misaligned) begin
          misalign_o   <= 1'b1;
          fault_addr_o <= addr_i;
        end else if (access) begin
          state        <= REQ;
          dbus_we_o    <= mem_wr_en_i;
          size_q       <= size;
          sign_q       <= ~mem_ctrl_i[2];
          addr_q       <= addr_i;
          dbus_be_o    <= be;
          dbus_wdata_o <= wdata_fmt;
          killed       <= 1'b0;
          cnt          <= '0;
        end
      end else if (state == DONE) begin
        state <= IDLE;
      end else if (abort) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (fin) begin
        state        <= DONE;
        cnt          <= '0;
        load_valid_o <= ld_ok & ~kill;
        err_o        <= berr & ~kill;
        load_data_o  <= ld_ok ? ld_fmt : '0;
        if (berr & ~kill) fault_addr_o <= addr_q;
      end else begin
        cnt    <= cnt + 8'd1;
        killed <= kill;
        if (state == REQ & dbus_gnt_i) state <= WAIT;
      end
    end
  end
endmodule

// File: doc/lsu_dbus_master.md
Name: lsu_dbus_master

Overview:
- Memory-stage load/store unit: the consumer end of the EX/MEM pipeline register.
- Takes the registered memory controls (rd/wr enables, mem_ctrl, ALU address, store data) and runs a single-outstanding request/response transaction on the data bus.
- Formats byte lanes and store data; extracts and extends load data.
- Holds the pipeline through stall_o until the access completes.

Parameters:
TIMEOUT_CYCLES, 255, cycles spent in REQ+WAIT before the access is forced to complete with err_o=1 (8-bit counter; range 1..255).
ALIGN_CHECK, 1, 1 = misaligned half/word accesses trap without a bus access; 0 = address low bits ignored, access issued word-aligned.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
pc_valid_i  in  1  MEM-stage instruction valid
mem_rd_en_i  in  1  load
mem_wr_en_i  in  1  store
mem_ctrl_i  in  4  [2:0]=funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU); [3] ignored
addr_i  in  32  effective address (ALU result)
wdata_i  in  32  store data (rs2)
flush_i  in  1  kill MEM-stage instruction
stall_o  out  1  hold EX/MEM and earlier stages
load_valid_o  out  1  one-cycle pulse, load_data_o valid
load_data_o  out  32  extended load result
misalign_o  out  1  one-cycle misalignment trap pulse
err_o  out  1  one-cycle bus error/timeout pulse
fault_addr_o  out  32  address of trapped access
dbus_req_o  out  1  request valid
dbus_we_o  out  1  1 = write
dbus_addr_o  out  32  word address, [1:0]=00
dbus_be_o  out  4  byte enables
dbus_wdata_o  out  32  lane-replicated store data
dbus_gnt_i  in  1  request accepted this cycle
dbus_rvalid_i  in  1  response valid (read data or write ack)
dbus_rdata_i  in  32  read data
dbus_err_i  in  1  response error, qualified by rvalid

Behaviour:
- Reset: state IDLE. All outputs 0, including dbus_addr_o/be/wdata and fault_addr_o. Timeout counter 0.
- access = pc_valid_i & (mem_rd_en_i | mem_wr_en_i) & !flush_i. If both enables are set, the store takes priority.
- Misaligned (ALIGN_CHECK=1): H/HU with addr[0]=1, or W with addr[1:0]!=0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, access & aligned:
  - stall_o=1 combinationally.
  - Latch we, size, sign, addr[1:0], be, wdata and the word address.
  - Go to REQ.
- IDLE, access & misaligned:
  - misalign_o=1 and fault_addr_o=addr_i, registered and visible the next cycle.
  - No stall, no bus activity; stay in IDLE.
- REQ: dbus_req_o=1 with stable addr/we/be/wdata. On dbus_gnt_i go to WAIT.
- WAIT:
  - On dbus_rvalid_i go to DONE.
  - Capture formatted load data, or 0 for stores and for errors.
  - Capture dbus_err_i.
- DONE:
  - stall_o=0.
  - load_valid_o=1 for a non-error load. err_o=1 with fault_addr_o=latched byte address on error.
  - Next state IDLE (the pipeline advances on this edge; the next instruction is sampled in IDLE).
- Minimum aligned latency: presented in cycle 0; REQ in cycle 1 with gnt; WAIT in cycle 2 with rvalid; DONE in cycle 3. That is 3 stall cycles.
- stall_o = (IDLE & access & aligned) | REQ | WAIT.
- Responses are sampled only in WAIT. rvalid in IDLE, REQ or DONE is ignored.
- Store lanes:
  - SB: be = 0001 << addr[1:0]; wdata = {4{wdata_i[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011; wdata = {2{wdata_i[15:0]}}.
  - SW: be = 1111; wdata = wdata_i.
- Loads: be as for stores.
  - Byte/half = rdata >> (8*addr[1:0]).
  - B/H sign-extend; BU/HU zero-extend; W passes through unchanged.
- Timeout:
  - The counter increments in REQ and WAIT and clears on leaving them.
  - Reaching TIMEOUT_CYCLES forces DONE with err_o=1 and dbus_req_o dropped.
  - A late response arriving afterwards is ignored.
- Flush:
  - In REQ without gnt in the same cycle: abort to IDLE, drop req, no pulses.
  - In REQ with gnt, or in WAIT: complete the bus transaction, but suppress load_valid_o/err_o in DONE.
  - Flush has no effect in DONE.
- rst in any state: IDLE next cycle, req dropped, pending response discarded.

Test Plan:
- LBU, addr 0x1003, rdata 0x80FF_0000 -> dbus_addr 0x1000, be 1000; load_data 0x0000_0080 in cycle 3; stall high cycles 0-2.
- LH, addr 0x2002, rdata 0x8001_1234 -> be 1100; load_data 0xFFFF_8001. LW, addr 0x2001 -> misalign_o pulse, fault_addr 0x2001, no req, stall_o 0.
- SB, addr 0x3001, wdata 0x1234_56AB -> we 1, be 0010, dbus_wdata 0xABAB_ABAB. gnt delayed 4 cycles -> req held with stable fields; stall stays high until DONE.
- Load with rvalid+err, addr 0x4000 -> err_o pulse, fault_addr 0x4000, load_valid_o 0. No gnt for 255 cycles -> err_o at timeout; a later rvalid is ignored.
- flush_i in REQ before gnt -> req drops next cycle, IDLE, no pulses. flush_i in WAIT -> rvalid consumed, no load_valid_o.
- rst asserted in WAIT -> all outputs 0 next cycle; an rvalid the following cycle causes no pulse; a new LW then completes normally.
